aes_key_expand_seq: RTL and testbench
=====================================

Name: aes_key_expand_seq

Overview:
- Sequential AES-128 key expansion engine that feeds the per-round key schedule datapath and the cipher round stages downstream.
- Accepts one 128-bit cipher key and generates round keys 0..10 at one round per clock.
- Stores all eleven round keys in an internal buffer.
- Serves round keys to the cipher core through an indexed, registered read port.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; only 10 (AES-128) is supported; any other value is a compile-time error.
- KEY_W, 128, round key width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new expansion; accepted only when busy=0.
- key_in  input  128  cipher key, bit 127 is the MSB of word w0; sampled on the accepted start.
- busy  output  1  high while expansion is in progress.
- done  output  1  high once all 11 round keys are valid; held until the next accepted start.
- rd_idx  input  4  round key index 0..10.
- rd_key  output  128  round key selected by rd_idx; registered.
- rd_valid  output  1  registered qualifier for rd_key.

Behaviour:
- Reset (rst_n=0 at an edge):
  - busy=0, done=0, rd_key=0, rd_valid=0.
  - Round counter=0, rcon=8'h01, FSM=IDLE.
  - Buffer contents are undefined unless KEYSCHED_ZEROIZE_EN is defined.
- FSM states:
  - IDLE: waiting for start.
  - EXPAND: generating round keys.
  - DONE: all keys valid.
- IDLE --start--> EXPAND:
  - On the accepting edge: buf[0]<=key_in, working key<=key_in, cnt<=1, rcon<=01, busy<=1, done<=0.
- EXPAND, each cycle:
  - Temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - buf[cnt]<=next key; working key<=next key; cnt<=cnt+1.
  - rcon<=xtime(rcon): shift left 1; if bit 7 was set, XOR 8'h1b (gives 01,02,04,..,80,1b,36).
- EXPAND -> DONE:
  - When cnt=10 is written: busy<=0, done<=1.
  - Latency: start edge at cycle 0; done visible after cycle 10 (11 edges including the accept).
- DONE --start--> EXPAND:
  - Same actions as from IDLE; done drops on the accepting edge.
- start while busy=1: ignored; no queueing; key_in is not sampled.
- Read port:
  - rd_key<=buf[rd_idx] every cycle.
  - rd_valid<=done && (rd_idx<=10).
  - rd_idx in 11..15: rd_key<=0, rd_valid<=0.
  - Reads during EXPAND return rd_valid=0; rd_key data is don't-care.
- Reset mid-expansion:
  - Aborts immediately; state returns to reset values; partial keys are not reported as valid.
- S-box: combinational, four instances, used for SubWord only.

Optional Feature:
- Macro: KEYSCHED_ZEROIZE_EN.
- Defined:
  - Reset clears all 11 buffer entries to 0.
  - An accepted start clears entries 1..10 on the same edge that loads entry 0.
  - No prior-key material is readable after reset; guarantees rd_key=0 for every index out of reset.
- Undefined:
  - Buffer has no reset and no clear, so it infers as plain RAM/registers.
  - Stale entries stay in place, but rd_valid masks them.

Decomposition:
- Shared package aes_pkg holds:
  - Constants AES_KEY_W=128, AES_NUM_ROUNDS=10.
  - Round index type (4-bit).
  - The 256-entry S-box constant table.
  - xtime function.
  - FSM state enum {IDLE, EXPAND, DONE}.
- One sub-module: aes_key_round_step. Purely combinational.
  - Inputs: key, rcon. Output: next key.
  - Contains the RotWord, SubWord and XOR chain.
  - Reusable by the unrolled per-round key schedule blocks.

Test Plan:
- Reset, then start with key 2b7e1516_28aed2a6_abf71588_09cf4f3c:
  - busy=1 for exactly 10 cycles, then done=1.
  - rd_idx=1 -> a0fafe17_88542cb1_23a33939_2a6c7605 with rd_valid=1 one cycle later.
- Same key, read rd_idx=2 -> f2c295f2_7a96b943_5935807a_7359f67f.
- Same key, read rd_idx=10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- Same key, read rd_idx=0 -> the key itself.
- Same key, read rd_idx=11 or 15 -> rd_key=0, rd_valid=0.
- Pulse start with key 0 at cycle 4 of an expansion of the FIPS key:
  - Ignored; final rd_idx=10 still equals d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- rst_n=0 at cycle 5 of an expansion:
  - Next cycle busy=0, done=0, rd_valid=0.
  - A fresh start with key 0 gives rd_idx=10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- With KEYSCHED_ZEROIZE_EN defined:
  - After reset, rd_key=0 for every rd_idx.
  - After a start, entries 1..10 read back as 0 via a hierarchical probe on the accepting edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule definitions: sizes, round index type, FSM states,
// the forward S-box table and the GF(2^8) xtime helper.
package aes_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;

  typedef logic [3:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key schedule round: RotWord, SubWord, rcon injection and the
// w0..w3 XOR chain. Purely combinational; shared with unrolled schedules.
module aes_key_round_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] key,
  input  logic [7:0]           rcon,
  output logic [AES_KEY_W-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub[8*b +: 8] = SBOX[rot[8*b +: 8]];
  end

  assign temp = sub ^ {rcon, 24'h0};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key expansion, one round per clock, into an 11-entry
// round key buffer with a registered read port. KEYSCHED_ZEROIZE_EN clears the buffer.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid
);

  if (NUM_ROUNDS != AES_NUM_ROUNDS || KEY_W != AES_KEY_W) begin : g_bad_cfg
    $error("aes_key_expand_seq supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
  end

  localparam round_idx_t LAST_IDX = round_idx_t'(AES_NUM_ROUNDS);

  ks_state_e        state_q, state_d;
  round_idx_t       cnt_q, cnt_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [KEY_W-1:0] wkey_q, wkey_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic             rd_valid_q, rd_valid_d;

  logic [KEY_W-1:0] key_buf_q [AES_NUM_ROUNDS+1];
  logic             buf_we;
  round_idx_t       buf_waddr;
  logic [KEY_W-1:0] buf_wdata;
  logic [KEY_W-1:0] next_key;

  aes_key_round_step u_step (
    .key      (wkey_q),
    .rcon     (rcon_q),
    .next_key (next_key)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcon_d    = rcon_q;
    wkey_d    = wkey_q;
    busy_d    = busy_q;
    done_d    = done_q;
    buf_we    = 1'b0;
    buf_waddr = cnt_q;
    buf_wdata = next_key;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = EXPAND;
          cnt_d     = round_idx_t'(1);
          rcon_d    = 8'h01;
          wkey_d    = key_in;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          buf_we    = 1'b1;
          buf_waddr = '0;
          buf_wdata = key_in;
        end
      end
      EXPAND: begin
        // start is deliberately not looked at here: no queueing while busy
        buf_we = 1'b1;
        wkey_d = next_key;
        cnt_d  = cnt_q + round_idx_t'(1);
        rcon_d = xtime(rcon_q);
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= AES_NUM_ROUNDS; i++) begin
      if (rd_idx == i[3:0]) rd_key_d = key_buf_q[i];
    end
    rd_valid_d = done_q && (rd_idx <= LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rcon_q     <= 8'h01;
      wkey_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcon_q     <= rcon_d;
      wkey_q     <= wkey_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef KEYSCHED_ZEROIZE_EN
  // A write to entry 0 is always an accepted start, so it also wipes 1..10.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= AES_NUM_ROUNDS; i++) key_buf_q[i] <= '0;
    end else begin
      for (int i = 0; i <= AES_NUM_ROUNDS; i++) begin
        if (buf_we && buf_waddr == i[3:0])
          key_buf_q[i] <= buf_wdata;
        else if (buf_we && buf_waddr == '0 && i != 0)
          key_buf_q[i] <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int i = 0; i <= AES_NUM_ROUNDS; i++) begin
      if (buf_we && buf_waddr == i[3:0]) key_buf_q[i] <= buf_wdata;
    end
  end
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_key   = rd_key_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: FIPS-197 vectors plus random keys against a
// GF(2^8)-derived key schedule model. Zeroize checks run with KEYSCHED_ZEROIZE_EN.
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK2 = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic [7:0]   m_sbox [256];
  logic [127:0] m_rk   [11];

  aes_key_expand_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .rd_idx   (rd_idx),
    .rd_key   (rd_key),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (field arithmetic, word recurrence) -----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus drivers (no checking inside) -------------------
  // Starts an expansion; optionally pulses start with another key at cycle inj.
  task automatic run_expand(input logic [127:0] k, input int inj, input logic [127:0] inj_key,
                            output int busy_cycles, output logic done_at_accept);
    @(negedge clk);
    start = 1'b1;
    key_in = k;
    busy_cycles = 0;
    done_at_accept = 1'bx;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      if (c == 0) done_at_accept = done;
      if (c == inj) begin
        start = 1'b1;
        key_in = inj_key;
      end
      if (busy) busy_cycles++;
      else break;
    end
    start = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] idx);
    @(negedge clk);
    rd_idx = idx;
    @(negedge clk);
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    key_in = '0;
    rd_idx = 4'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_key !== '0) begin n_err++; $display("FAIL reset_rd_key: got %h want 0", rd_key); end
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    int bc;
    logic dacc;
    run_expand(FIPS_KEY, -1, '0, bc, dacc);
    n_cmp++; if (bc != 10) begin n_err++; $display("FAIL fips_busy_cycles: got %0d want 10", bc); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fips_done: got %b want 1", done); end
    do_read(4'd1);
    n_cmp++; if (rd_key !== FIPS_RK1 || rd_valid !== 1'b1) begin n_err++; $display("FAIL fips_rk1: got %h/%b want %h/1", rd_key, rd_valid, FIPS_RK1); end
    do_read(4'd2);
    n_cmp++; if (rd_key !== FIPS_RK2 || rd_valid !== 1'b1) begin n_err++; $display("FAIL fips_rk2: got %h/%b want %h/1", rd_key, rd_valid, FIPS_RK2); end
    do_read(4'd10);
    n_cmp++; if (rd_key !== FIPS_RK10 || rd_valid !== 1'b1) begin n_err++; $display("FAIL fips_rk10: got %h/%b want %h/1", rd_key, rd_valid, FIPS_RK10); end
    do_read(4'd0);
    n_cmp++; if (rd_key !== FIPS_KEY || rd_valid !== 1'b1) begin n_err++; $display("FAIL fips_rk0: got %h/%b want %h/1", rd_key, rd_valid, FIPS_KEY); end
    do_read(4'd11);
    n_cmp++; if (rd_key !== '0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL fips_idx11: got %h/%b want 0/0", rd_key, rd_valid); end
    do_read(4'd15);
    n_cmp++; if (rd_key !== '0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL fips_idx15: got %h/%b want 0/0", rd_key, rd_valid); end
  endtask

  task automatic test_start_while_busy();
    int bc;
    logic dacc;
    run_expand(FIPS_KEY, 4, '0, bc, dacc);
    n_cmp++; if (bc != 10) begin n_err++; $display("FAIL busy_start_cycles: got %0d want 10", bc); end
    n_cmp++; if (dacc !== 1'b0) begin n_err++; $display("FAIL restart_done_drop: got %b want 0", dacc); end
    do_read(4'd10);
    n_cmp++; if (rd_key !== FIPS_RK10 || rd_valid !== 1'b1) begin n_err++; $display("FAIL busy_start_rk10: got %h/%b want %h/1", rd_key, rd_valid, FIPS_RK10); end
  endtask

  task automatic test_reset_mid_expand();
    int bc;
    logic dacc;
    @(negedge clk);
    start = 1'b1;
    key_in = FIPS_KEY;
    rd_idx = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL expand_rd_valid: got %b want 0", rd_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0)
      begin n_err++; $display("FAIL mid_reset: got busy=%b done=%b valid=%b want 0/0/0", busy, done, rd_valid); end
    run_expand('0, -1, '0, bc, dacc);
    n_cmp++; if (bc != 10) begin n_err++; $display("FAIL zero_busy_cycles: got %0d want 10", bc); end
    do_read(4'd10);
    n_cmp++; if (rd_key !== ZERO_RK10 || rd_valid !== 1'b1) begin n_err++; $display("FAIL zero_rk10: got %h/%b want %h/1", rd_key, rd_valid, ZERO_RK10); end
  endtask

  task automatic test_random_keys();
    int bc;
    logic dacc;
    logic [127:0] k;
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      run_expand(k, -1, '0, bc, dacc);
      n_cmp++; if (bc != 10 || done !== 1'b1) begin n_err++; $display("FAIL rand%0d_timing: got busy=%0d done=%b want 10/1", t, bc, done); end
      for (int r = 0; r < 11; r++) begin
        do_read(4'(r));
        n_cmp++; if (rd_key !== m_rk[r] || rd_valid !== 1'b1)
          begin n_err++; $display("FAIL rand%0d_rk%0d: got %h/%b want %h/1", t, r, rd_key, rd_valid, m_rk[r]); end
      end
      do_read(4'($urandom_range(11, 15)));
      n_cmp++; if (rd_key !== '0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL rand%0d_oob: got %h/%b want 0/0", t, rd_key, rd_valid); end
    end
  endtask

`ifdef KEYSCHED_ZEROIZE_EN
  task automatic test_zeroize();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      do_read(4'(r));
      n_cmp++; if (rd_key !== '0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL zeroize_reset_idx%0d: got %h/%b want 0/0", r, rd_key, rd_valid); end
    end
    // Fill the buffer, then check a new start wipes entries 1..10 on its accepting edge.
    model_expand(FIPS_KEY);
    begin
      int bc;
      logic dacc;
      run_expand(FIPS_KEY, -1, '0, bc, dacc);
    end
    @(negedge clk);
    start = 1'b1;
    key_in = 128'h00112233_44556677_8899aabb_ccddeeff;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (dut.key_buf_q[0] !== 128'h00112233_44556677_8899aabb_ccddeeff)
      begin n_err++; $display("FAIL zeroize_entry0: got %h want 00112233445566778899aabbccddeeff", dut.key_buf_q[0]); end
    for (int r = 1; r < 11; r++) begin
      n_cmp++; if (dut.key_buf_q[r] !== '0) begin n_err++; $display("FAIL zeroize_entry%0d: got %h want 0", r, dut.key_buf_q[r]); end
    end
    repeat (12) @(negedge clk);
  endtask
`endif

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_start_while_busy();
    test_reset_mid_expand();
    test_random_keys();
`ifdef KEYSCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
